wb_arb2_rr: RTL and testbench
=============================

// Module: wb_arb2_rr
// PURPOSE
//  Two-master to one-slave Wishbone round-robin arbiter. Sits between the LM32 instruction and data
//  ports and a shared slave (e.g. bram0 or one conbus slot), serialising cycles, holding the grant
//  for a whole CYC and aborting hung slave accesses with ERR. Registered grant, combinational datapath.
// PARAMETERS
//  ADR_W    32   address width
//  DAT_W    32   data width; SEL width = DAT_W/8
//  TIMEOUT  255  stalled-STB cycles before abort (1..65535); used only with WB_ARB_TIMEOUT_EN
// PORTS
//  clk                   in   1        system clock
//  rst                   in   1        synchronous reset, active-low
//  m0_/m1_adr_i          in   ADR_W    master address
//  m0_/m1_dat_i          in   DAT_W    master write data
//  m0_/m1_sel_i          in   DAT_W/8  byte selects
//  m0_/m1_we_i           in   1        write enable
//  m0_/m1_cyc_i          in   1        bus request / cycle
//  m0_/m1_stb_i          in   1        strobe
//  m0_/m1_dat_o          out  DAT_W    read data (s_dat_i broadcast to both)
//  m0_/m1_ack_o          out  1        ack, granted master only
//  m0_/m1_err_o          out  1        timeout error, granted master only
//  s_adr_o,s_dat_o       out  ADR_W,DAT_W  muxed address / write data
//  s_sel_o,s_we_o        out  DAT_W/8,1    muxed selects / write enable
//  s_cyc_o,s_stb_o       out  1        muxed cycle / strobe, gated by grant
//  s_dat_i,s_ack_i       in   DAT_W,1  slave read data / ack
//  timeout_o             out  1        one-cycle pulse on each abort (IRQ source)
// BEHAVIOUR
//  - States: IDLE, G0, G1 (registered). Reset (rst==0 at posedge): IDLE, last=1 (m0 wins first tie),
//    counter=0. In IDLE all s_cyc_o/s_stb_o/m*_ack_o/m*_err_o/timeout_o = 0; s_adr/dat/sel/we = m0 values.
//  - IDLE: m0_cyc only -> G0; m1_cyc only -> G1; both -> master != last; none -> IDLE.
//  - Gn: slave signals = master n; s_cyc_o=mn_cyc_i, s_stb_o=mn_stb_i; mn_ack_o=s_ack_i; other ack/err=0.
//    Leave when mn_cyc_i==0: other master's cyc high -> G(other), else IDLE; last<=n on exit.
//  - Grant latency: request seen in IDLE -> slave sees cycle next clock (1-cycle arbitration).
//    Handover Gn->G(other) is direct, no IDLE bubble; exiting cycle drives s_cyc_o=0.
//  - Grant never preempted mid-CYC; burst/lock held as long as CYC stays high.
//  - ACK from slave while no grant or STB low is dropped (never routed).
//  - Both cyc drop and rise same clock: rule above, requester evaluated on that clock's inputs.
//  - Reset mid-cycle: grant lost immediately next clock; slave sees s_cyc_o=0.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//    16-bit counter: clears on s_ack_i, on s_stb_o==0, in IDLE; else +1 per clock (saturating).
//    When counter==TIMEOUT and no s_ack_i: that clock mn_err_o=1, s_stb_o=0, timeout_o=1, counter<=0;
//    grant stays until master drops CYC. ACK on the same clock as the limit wins (no err).
//  Not defined: no counter; m*_err_o and timeout_o tied 0; stalled slave holds grant forever.
// TESTING
//  1 reset: rst=0 for 3 clks with both cyc=1 -> s_cyc_o=0, acks 0; release -> G0 next clk (m0 wins tie).
//  2 tie fairness: both cyc/stb held, slave acks each cycle, masters drop cyc after 1 ack ->
//    grants alternate G0,G1,G0,G1 with no IDLE clock between.
//  3 isolation: G0 active, m1 write adr=0x20000004 pending -> s_adr_o=m0 adr, m1_ack_o=0 throughout.
//  4 mid-cycle reset: G1 with stb, rst=0 one clk -> s_cyc_o=0 next clk, state IDLE, last=1.
//  5 timeout (EN, TIMEOUT=4): m0 stb, no ack -> m0_err_o=1 and timeout_o=1 exactly on 5th stalled clk.
//  6 no EN: same stall 1000 clks -> err/timeout stay 0, s_stb_o stays 1.

Source files
------------

// File: rtl/wb_arb2_rr.sv
// wb_arb2_rr: two-master to one-slave Wishbone round-robin arbiter.
//
// Serialises Wishbone cycles from two masters (e.g. LM32 I and D ports) onto one shared slave.
// The grant is registered: a request seen in IDLE reaches the slave on the next clock. Once a
// master is granted, it keeps the bus for its whole CYC. The address/data path is combinational.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to abort stalled strobes with ERR after TIMEOUT
// clocks. Without it, m*_err_o and timeout_o are tied low.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   m0_* / m1_*              master ports: adr/dat/sel/we/cyc/stb in, dat/ack/err out
//   s_*_o                    muxed slave request (cyc/stb gated by grant)
//   s_dat_i, s_ack_i         slave read data and acknowledge
//   timeout_o                one-cycle pulse for each aborted access

module wb_arb2_rr #(
    parameter int unsigned ADR_W   = 32,
    parameter int unsigned DAT_W   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [ADR_W-1:0]     m0_adr_i,
    input  logic [DAT_W-1:0]     m0_dat_i,
    input  logic [DAT_W/8-1:0]   m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    output logic [DAT_W-1:0]     m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic [ADR_W-1:0]     m1_adr_i,
    input  logic [DAT_W-1:0]     m1_dat_i,
    input  logic [DAT_W/8-1:0]   m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    output logic [DAT_W-1:0]     m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic [ADR_W-1:0]     s_adr_o,
    output logic [DAT_W-1:0]     s_dat_o,
    output logic [DAT_W/8-1:0]   s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [DAT_W-1:0]     s_dat_i,
    input  logic                 s_ack_i,

    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StG0   = 2'd1,
        StG1   = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;   // master that most recently owned the bus

    logic gnt0, gnt1, granted;
    logic g_cyc, g_stb;
    logic abort;

    // Grant state machine

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // Tie: whoever did not own the bus last wins.
                    state_d = last_q ? StG0 : StG1;
                end else if (m0_cyc_i) begin
                    state_d = StG0;
                end else if (m1_cyc_i) begin
                    state_d = StG1;
                end
            end
            StG0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? StG1 : StIdle;
                end
            end
            StG1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? StG0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Datapath

    always_comb begin
        gnt0    = (state_q == StG0);
        gnt1    = (state_q == StG1);
        granted = gnt0 | gnt1;

        // IDLE presents master 0 on the address/data lines.
        s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
        s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
        s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
        s_we_o  = gnt1 ? m1_we_i  : m0_we_i;

        g_cyc   = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
        g_stb   = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);

        s_cyc_o = g_cyc;
        s_stb_o = g_stb & ~abort;

        // Acks only reach the granted master and only against an active strobe.
        m0_ack_o  = gnt0 & g_stb & s_ack_i;
        m1_ack_o  = gnt1 & g_stb & s_ack_i;
        m0_err_o  = gnt0 & abort;
        m1_err_o  = gnt1 & abort;
        timeout_o = abort;

        m0_dat_o  = s_dat_i;
        m1_dat_o  = s_dat_i;
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] Limit = 16'(TIMEOUT);

    logic [15:0] cnt_q, cnt_d;

    // An ack on the limit clock wins over the abort.
    assign abort = granted & g_stb & ~s_ack_i & (cnt_q == Limit);

    always_comb begin
        cnt_d = cnt_q;
        if (!granted || !g_stb || s_ack_i || abort) begin
            cnt_d = 16'd0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign unused_timeout = ^TIMEOUT ^ granted;
`endif

endmodule

// File: tb/tb_wb_arb2_rr.sv
module tb_wb_arb2_rr;

    localparam int unsigned TIMEOUT = 4;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic        we  [2];
    logic        cyc [2];
    logic        stb [2];

    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, timeout_o;

    int errors = 0;
    int checks = 0;

    // Reference model: owner (-1 = nobody), last owner, stall count.
    int mg, mlast, mcnt;

    always #5 clk = ~clk;

    wb_arb2_rr #(
        .ADR_W  (32),
        .DAT_W  (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_adr_i (adr[0]),
        .m0_dat_i (dat[0]),
        .m0_sel_i (sel[0]),
        .m0_we_i  (we[0]),
        .m0_cyc_i (cyc[0]),
        .m0_stb_i (stb[0]),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (adr[1]),
        .m1_dat_i (dat[1]),
        .m1_sel_i (sel[1]),
        .m1_we_i  (we[1]),
        .m1_cyc_i (cyc[1]),
        .m1_stb_i (stb[1]),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .timeout_o(timeout_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_abort();
        int g;
        g = (mg < 0) ? 0 : mg;
        return EN && (mg >= 0) && (mcnt == int'(TIMEOUT)) && !s_ack_i && stb[g];
    endfunction

    task automatic model_check();
        int   g;
        bit   ab;
        logic e_cyc, e_stb;
        logic [1:0] e_ack, e_err;
        g     = (mg < 0) ? 0 : mg;
        ab    = model_abort();
        e_cyc = (mg >= 0) && cyc[g];
        e_stb = (mg >= 0) && stb[g] && !ab;
        e_ack = 2'b00;
        e_err = 2'b00;
        if (mg >= 0) begin
            e_ack[g] = s_ack_i && stb[g] && !ab;
            e_err[g] = ab;
        end
        chk("s_adr", s_adr_o, adr[g]);
        chk("s_dat", s_dat_o, dat[g]);
        chk("s_sel", s_sel_o, sel[g]);
        chk("s_we", s_we_o, we[g]);
        chk("s_cyc", s_cyc_o, e_cyc);
        chk("s_stb", s_stb_o, e_stb);
        chk("m0_ack", m0_ack_o, e_ack[0]);
        chk("m1_ack", m1_ack_o, e_ack[1]);
        chk("m0_err", m0_err_o, e_err[0]);
        chk("m1_err", m1_err_o, e_err[1]);
        chk("timeout", timeout_o, ab);
        chk("m0_dat", m0_dat_o, s_dat_i);
        chk("m1_dat", m1_dat_o, s_dat_i);
    endtask

    task automatic model_advance();
        int g;
        bit ab;
        g  = (mg < 0) ? 0 : mg;
        ab = model_abort();
        if (!rst) begin
            mg = -1; mlast = 1; mcnt = 0;
        end else if (mg < 0) begin
            mcnt = 0;
            if (cyc[0] && cyc[1]) mg = 1 - mlast;
            else if (cyc[0])      mg = 0;
            else if (cyc[1])      mg = 1;
        end else begin
            if (ab || s_ack_i || !stb[g]) mcnt = 0;
            else if (mcnt < 65535)        mcnt = mcnt + 1;
            if (!cyc[g]) begin
                mlast = g;
                mg    = cyc[1-g] ? 1 - g : -1;
            end
        end
    endtask

    // Compare at the falling edge, advance the model, then let the DUT clock.
    task automatic cyc_step();
        @(negedge clk);
        model_check();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        adr[0] = 32'h1000_0000; adr[1] = 32'h2000_0000;
        dat[0] = 32'hAAAA_0000; dat[1] = 32'hBBBB_0000;
        sel[0] = 4'hF;          sel[1] = 4'h3;
        we[0]  = 1'b0;          we[1]  = 1'b1;
        cyc[0] = 1'b1;          cyc[1] = 1'b1;
        stb[0] = 1'b1;          stb[1] = 1'b1;
        s_ack_i = 1'b1;
        s_dat_i = 32'hCAFE_0001;
        mg = -1; mlast = 1; mcnt = 0;
        @(posedge clk);
        #1;

        // Reset held with both masters requesting: nothing reaches the slave.
        repeat (3) begin
            chk("rst_s_cyc", s_cyc_o, 1'b0);
            chk("rst_m0_ack", m0_ack_o, 1'b0);
            chk("rst_m1_ack", m1_ack_o, 1'b0);
            cyc_step();
        end
        rst = 1'b1;
        cyc_step();

        // Tie fairness: each master drops CYC after one ack, grants alternate directly.
        for (int k = 0; k < 8; k++) begin
            int ph;
            ph = k % 4;
            cyc[0] = (ph != 1); stb[0] = (ph != 1);
            cyc[1] = (ph != 3); stb[1] = (ph != 3);
            #1;
            chk("rr_adr", s_adr_o, (ph < 2) ? 32'h1000_0000 : 32'h2000_0000);
            chk("rr_cyc", s_cyc_o, (ph == 0 || ph == 2));
            chk("rr_m0_ack", m0_ack_o, (ph == 0));
            chk("rr_m1_ack", m1_ack_o, (ph == 2));
            cyc_step();
        end

        // Isolation: m0 holds the bus while m1 has a write pending.
        adr[0] = 32'h1000_0010; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
        adr[1] = 32'h2000_0004; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (6) begin
            s_ack_i = 1'($urandom % 2);
            #1;
            chk("iso_adr", s_adr_o, 32'h1000_0010);
            chk("iso_we", s_we_o, 1'b0);
            chk("iso_cyc", s_cyc_o, 1'b1);
            chk("iso_m1_ack", m1_ack_o, 1'b0);
            cyc_step();
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        #1;
        chk("exit_cyc", s_cyc_o, 1'b0);
        cyc_step();

        // Mid-cycle reset while m1 owns the bus.
        s_ack_i = 1'b0;
        #1;
        chk("g1_adr", s_adr_o, 32'h2000_0004);
        chk("g1_cyc", s_cyc_o, 1'b1);
        rst = 1'b0;
        cyc_step();
        rst = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
        #1;
        chk("mrst_cyc", s_cyc_o, 1'b0);
        chk("mrst_stb", s_stb_o, 1'b0);
        cyc_step();
        #1;
        chk("mrst_tie_adr", s_adr_o, 32'h1000_0010);
        chk("mrst_tie_cyc", s_cyc_o, 1'b1);
        cyc_step();

        // Randomised traffic against the model.
        repeat (2500) begin
            rst = (($urandom % 64) != 0);
            for (int n = 0; n < 2; n++) begin
                if (cyc[n]) cyc[n] = (($urandom % 5) != 0);
                else        cyc[n] = (($urandom % 3) == 0);
                stb[n] = cyc[n] && (($urandom % 4) != 0);
                adr[n] = $urandom;
                dat[n] = $urandom;
                sel[n] = 4'($urandom);
                we[n]  = 1'($urandom);
            end
            s_ack_i = (($urandom % 3) == 0);
            s_dat_i = $urandom;
            cyc_step();
        end

        // Stall: m0 strobes, slave never acks.
        rst = 1'b1; s_ack_i = 1'b0;
        cyc[0] = 1'b0; stb[0] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (2) cyc_step();
        adr[0] = 32'h1000_0020; cyc[0] = 1'b1; stb[0] = 1'b1;
        cyc_step();
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk("to_err", m0_err_o, (k == 5));
            chk("to_pulse", timeout_o, (k == 5));
            chk("to_stb", s_stb_o, (k != 5));
            cyc_step();
        end
        // Ack arriving on the limit clock beats the abort.
        for (int k = 7; k <= 10; k++) begin
            s_ack_i = (k == 10);
            #1;
            chk("lim_ack", m0_ack_o, (k == 10));
            chk("lim_err", m0_err_o, 1'b0);
            chk("lim_pulse", timeout_o, 1'b0);
            cyc_step();
        end
`else
        repeat (1000) begin
            #1;
            chk("stall_err", m0_err_o, 1'b0);
            chk("stall_pulse", timeout_o, 1'b0);
            chk("stall_stb", s_stb_o, 1'b1);
            cyc_step();
        end
`endif
        cyc[0] = 1'b0; stb[0] = 1'b0; s_ack_i = 1'b0;
        cyc_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
